// File: rtl/pipe_ctrl.sv
// Pipeline control for the 5-stage core: folds memory waits, MDU occupancy, load-use
// hazards and redirects/traps into the shared all_ready / stall / flush control word.
module pipe_ctrl #(
    parameter int unsigned PC_W    = 64,
    parameter int unsigned MUL_LAT = 3,
    parameter int unsigned DIV_LAT = 65
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ireq_valid,
    input  logic            iresp_ok,
    input  logic            dreq_valid,
    input  logic            dresp_ok,
    input  logic            mul_start,
    input  logic            div_start,
    input  logic            load_use,
    input  logic            redirect_in,
    input  logic [PC_W-1:0] redirect_pc_in,
    input  logic            trap_in,
    input  logic [PC_W-1:0] trap_pc_in,
    output logic            all_ready,
    output logic            stall_f,
    output logic            stall_d,
    output logic            flush_d,
    output logic            flush_e,
    output logic            flush_m,
    output logic            pc_redirect,
    output logic [PC_W-1:0] pc_target
);

    localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int unsigned CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] mdu_cnt_q, mdu_cnt_d;
    logic             rd_pend_q, rd_pend_d;
    logic [PC_W-1:0]  rd_pc_q, rd_pc_d;
    logic             tr_pend_q, tr_pend_d;
    logic [PC_W-1:0]  tr_pc_q, tr_pc_d;

    logic             mdu_idle;
    logic             imem_wait;
    logic             dmem_wait;
    logic             trap_eff;
    logic             redirect_eff;
    logic [PC_W-1:0]  trap_target;
    logic [PC_W-1:0]  redirect_target;
    logic             apply_ok;

    assign mdu_idle  = (mdu_cnt_q == '0) & ~mul_start & ~div_start;
    assign imem_wait = ireq_valid & ~iresp_ok;
    assign dmem_wait = dreq_valid & ~dresp_ok;
    assign all_ready = mdu_idle & ~imem_wait & ~dmem_wait;

    assign trap_eff        = tr_pend_q | trap_in;
    assign trap_target     = tr_pend_q ? tr_pc_q : trap_pc_in;
    assign redirect_eff    = rd_pend_q | redirect_in;
    assign redirect_target = rd_pend_q ? rd_pc_q : redirect_pc_in;

    // Control outputs stay quiet while reset is asserted even though all_ready may be high.
    assign apply_ok = all_ready & reset;

    // MDU occupancy: the start cycle itself is covered by mul_start/div_start in mdu_idle,
    // so the counter only needs to cover the remaining LAT-1 cycles.
    always_comb begin
        mdu_cnt_d = mdu_cnt_q;
        if (mdu_cnt_q != '0) begin
            mdu_cnt_d = mdu_cnt_q - CNT_ONE;
        end else if (div_start) begin
            mdu_cnt_d = DIV_LOAD;
        end else if (mul_start) begin
            mdu_cnt_d = MUL_LOAD;
        end
    end

    // Pending capture keeps the oldest request; applying a trap also kills any redirect.
    always_comb begin
        rd_pend_d = rd_pend_q;
        rd_pc_d   = rd_pc_q;
        tr_pend_d = tr_pend_q;
        tr_pc_d   = tr_pc_q;
        if (!all_ready) begin
            if (trap_in && !tr_pend_q) begin
                tr_pend_d = 1'b1;
                tr_pc_d   = trap_pc_in;
            end
            if (redirect_in && !rd_pend_q) begin
                rd_pend_d = 1'b1;
                rd_pc_d   = redirect_pc_in;
            end
        end else if (trap_eff) begin
            tr_pend_d = 1'b0;
            rd_pend_d = 1'b0;
        end else if (redirect_eff) begin
            rd_pend_d = 1'b0;
        end
    end

    always_comb begin
        stall_f     = 1'b0;
        stall_d     = 1'b0;
        flush_d     = 1'b0;
        flush_e     = 1'b0;
        flush_m     = 1'b0;
        pc_redirect = 1'b0;
        pc_target   = '0;
        if (apply_ok) begin
            if (trap_eff) begin
                pc_redirect = 1'b1;
                pc_target   = trap_target;
                flush_d     = 1'b1;
                flush_e     = 1'b1;
                flush_m     = 1'b1;
            end else if (redirect_eff) begin
                pc_redirect = 1'b1;
                pc_target   = redirect_target;
                flush_d     = 1'b1;
                flush_e     = 1'b1;
            end else if (load_use) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                flush_e = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mdu_cnt_q <= '0;
            rd_pend_q <= 1'b0;
            rd_pc_q   <= '0;
            tr_pend_q <= 1'b0;
            tr_pc_q   <= '0;
        end else begin
            mdu_cnt_q <= mdu_cnt_d;
            rd_pend_q <= rd_pend_d;
            rd_pc_q   <= rd_pc_d;
            tr_pend_q <= tr_pend_d;
            tr_pc_q   <= tr_pc_d;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl; control word packed as
// {all_ready, stall_f, stall_d, flush_d, flush_e, flush_m, pc_redirect}.
module tb_pipe_ctrl;

    localparam int unsigned PC_W = 64;

    logic            clk;
    logic            reset;
    logic            ireq_valid, iresp_ok, dreq_valid, dresp_ok;
    logic            mul_start, div_start, load_use;
    logic            redirect_in, trap_in;
    logic [PC_W-1:0] redirect_pc_in, trap_pc_in;
    logic            all_ready, stall_f, stall_d, flush_d, flush_e, flush_m, pc_redirect;
    logic [PC_W-1:0] pc_target;
    logic [6:0]      ctrl;

    int n_tests = 0;
    int n_fail  = 0;

    pipe_ctrl #(
        .PC_W    (PC_W),
        .MUL_LAT (3),
        .DIV_LAT (65)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .ireq_valid     (ireq_valid),
        .iresp_ok       (iresp_ok),
        .dreq_valid     (dreq_valid),
        .dresp_ok       (dresp_ok),
        .mul_start      (mul_start),
        .div_start      (div_start),
        .load_use       (load_use),
        .redirect_in    (redirect_in),
        .redirect_pc_in (redirect_pc_in),
        .trap_in        (trap_in),
        .trap_pc_in     (trap_pc_in),
        .all_ready      (all_ready),
        .stall_f        (stall_f),
        .stall_d        (stall_d),
        .flush_d        (flush_d),
        .flush_e        (flush_e),
        .flush_m        (flush_m),
        .pc_redirect    (pc_redirect),
        .pc_target      (pc_target)
    );

    assign ctrl = {all_ready, stall_f, stall_d, flush_d, flush_e, flush_m, pc_redirect};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [6:0] IDLE  = 7'b1000000;
    localparam logic [6:0] FROZE = 7'b0000000;
    localparam logic [6:0] REDIR = 7'b1001101;
    localparam logic [6:0] TRAP  = 7'b1001111;
    localparam logic [6:0] LDUSE = 7'b1110100;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [6:0] exp_ctrl,
                             input logic [63:0] exp_tgt);
        check_eq({tag, ".ctrl"}, 64'(ctrl), 64'(exp_ctrl));
        check_eq({tag, ".pc_target"}, pc_target, exp_tgt);
    endtask

    task automatic clear_inputs();
        ireq_valid = 0; iresp_ok = 0; dreq_valid = 0; dresp_ok = 0;
        mul_start = 0; div_start = 0; load_use = 0;
        redirect_in = 0; trap_in = 0;
        redirect_pc_in = '0; trap_pc_in = '0;
    endtask

    // Advance to the next negedge; inputs are driven there and outputs checked 2 time units later.
    task automatic next_cycle();
        @(negedge clk);
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        reset = 1'b0;

        // Reset held with a redirect request present
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            redirect_in = 1; redirect_pc_in = 64'h1234;
            #2 check_out("reset_hold", IDLE, 64'h0);
        end
        next_cycle();
        reset = 1'b1;
        #2 check_out("reset_release", IDLE, 64'h0);
        next_cycle();
        #2 check_out("reset_no_capture", IDLE, 64'h0);

        // Multiply: low for 3 cycles including the start cycle
        next_cycle();
        mul_start = 1;
        #2 check_eq("mul_c0", 64'(all_ready), 64'd0);
        for (int i = 1; i < 5; i++) begin
            next_cycle();
            #2 check_eq($sformatf("mul_c%0d", i), 64'(all_ready), (i < 3) ? 64'd0 : 64'd1);
        end

        // Divide: low for 65 cycles
        next_cycle();
        div_start = 1;
        #2 check_eq("div_c0", 64'(all_ready), 64'd0);
        for (int i = 1; i < 67; i++) begin
            next_cycle();
            #2 check_eq($sformatf("div_c%0d", i), 64'(all_ready), (i < 65) ? 64'd0 : 64'd1);
        end

        // Redirect captured during a 4-cycle data wait, applied on the response cycle
        next_cycle();
        dreq_valid = 1; redirect_in = 1; redirect_pc_in = 64'h8000_0040;
        #2 check_out("dwait_c0", FROZE, 64'h0);
        for (int i = 1; i < 4; i++) begin
            next_cycle();
            dreq_valid = 1; load_use = (i == 1);
            #2 check_out($sformatf("dwait_c%0d", i), FROZE, 64'h0);
        end
        next_cycle();
        dreq_valid = 1; dresp_ok = 1;
        #2 check_out("dwait_apply", REDIR, 64'h8000_0040);
        next_cycle();
        #2 check_out("dwait_after", IDLE, 64'h0);

        // Trap beats a same-cycle redirect
        next_cycle();
        trap_in = 1; trap_pc_in = 64'h8000_0100;
        redirect_in = 1; redirect_pc_in = 64'h8000_0040;
        #2 check_out("trap_vs_redir", TRAP, 64'h8000_0100);
        next_cycle();
        #2 check_out("trap_after", IDLE, 64'h0);

        // Load-use alone, then with a redirect
        next_cycle();
        load_use = 1;
        #2 check_out("load_use", LDUSE, 64'h0);
        next_cycle();
        load_use = 1; redirect_in = 1; redirect_pc_in = 64'h300;
        #2 check_out("load_use_redir", REDIR, 64'h300);

        // Two redirects during one MDU stall: the older one wins
        next_cycle();
        mul_start = 1; redirect_in = 1; redirect_pc_in = 64'h100;
        #2 check_out("two_redir_c0", FROZE, 64'h0);
        next_cycle();
        redirect_in = 1; redirect_pc_in = 64'h200;
        #2 check_out("two_redir_c1", FROZE, 64'h0);
        next_cycle();
        #2 check_out("two_redir_c2", FROZE, 64'h0);
        next_cycle();
        #2 check_out("two_redir_apply", REDIR, 64'h100);
        next_cycle();
        #2 check_out("two_redir_after", IDLE, 64'h0);

        // Pending trap and redirect both captured; the trap clears both
        next_cycle();
        ireq_valid = 1; redirect_in = 1; redirect_pc_in = 64'h500;
        #2 check_out("pend_both_c0", FROZE, 64'h0);
        next_cycle();
        ireq_valid = 1; trap_in = 1; trap_pc_in = 64'h600;
        #2 check_out("pend_both_c1", FROZE, 64'h0);
        next_cycle();
        ireq_valid = 1; iresp_ok = 1;
        #2 check_out("pend_both_apply", TRAP, 64'h600);
        next_cycle();
        #2 check_out("pend_both_after", IDLE, 64'h0);

        // Asynchronous reset in the middle of a divide with a pending redirect
        next_cycle();
        div_start = 1; redirect_in = 1; redirect_pc_in = 64'h700;
        #2 check_out("rst_mid_c0", FROZE, 64'h0);
        for (int i = 1; i < 4; i++) begin
            next_cycle();
            #2 check_eq($sformatf("rst_mid_c%0d", i), 64'(all_ready), 64'd0);
        end
        next_cycle();
        #1 reset = 1'b0;
        #1 check_out("rst_mid_async", IDLE, 64'h0);
        next_cycle();
        reset = 1'b1;
        #2 check_out("rst_mid_release", IDLE, 64'h0);
        next_cycle();
        #2 check_out("rst_mid_after", IDLE, 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
